// File: rtl/param_counter_pkg.sv
// Shared constants for the parametrised up/down counter: end-of-range mode
// selection (SATURATE parameter) and count direction encoding (up input).
package param_counter_pkg;

    typedef enum logic {
        CNT_MODE_WRAP = 1'b0,
        CNT_MODE_SAT  = 1'b1
    } cnt_mode_e;

    typedef enum logic {
        CNT_DIR_DOWN = 1'b0,
        CNT_DIR_UP   = 1'b1
    } cnt_dir_e;

endpackage

// File: rtl/param_updown_counter.sv
// Synchronous parametrised up/down counter with modulus, clamped parallel
// load and wrap/saturate end-of-range behaviour.
// Optional build macro PARAM_COUNTER_OVF_STICKY_EN adds the registered
// ovf_sticky output (set on wrap or on a saturated hold, cleared by rst/load).
module param_updown_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
`ifdef PARAM_COUNTER_OVF_STICKY_EN
    ,
    output logic             ovf_sticky
`endif
);

    localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
    localparam bit             SAT = (SATURATE == int'(CNT_MODE_SAT));

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   step_ext;
    logic             crossed;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    assign q_ext    = {1'b0, q};
    assign load_ext = {1'b0, load_val};

    // One extra bit lets MODULO = 2**WIDTH see its overflow and catches the
    // borrow when decrementing from zero.
    assign step_ext = (up == CNT_DIR_UP) ? (q_ext + ONE) : (q_ext - ONE);
    assign crossed  = (up == CNT_DIR_UP) ? (step_ext > MAX) : step_ext[WIDTH];

    // Terminal count depends only on the present count and direction.
    assign tc = (up == CNT_DIR_UP) ? (q_ext == MAX) : (q_ext == '0);

    // Next count and wrap pulse: load beats enable, end of range wraps or holds.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = (load_ext > MAX) ? MAX[WIDTH-1:0] : load_val;
        end else if (en) begin
            if (!crossed) begin
                q_next = step_ext[WIDTH-1:0];
            end else if (!SAT) begin
                q_next    = (up == CNT_DIR_UP) ? '0 : MAX[WIDTH-1:0];
                wrap_next = 1'b1;
            end
        end
    end

    // Count and wrap registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

`ifdef PARAM_COUNTER_OVF_STICKY_EN
    logic sticky_set;

    assign sticky_set = wrap_next | (SAT && en && !load && crossed);

    // Sticky overflow flag; load clears it even when a set coincides.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            ovf_sticky <= 1'b0;
        end else if (sticky_set) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: three instances (MODULO=10 wrap,
// MODULO=10 saturate, MODULO=16 wrap) share one stimulus stream; expected
// state is pushed when inputs are driven and compared on the next falling edge.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lv = 4'd0;

    logic [3:0] q_o    [3];
    logic       tc_o   [3];
    logic       wrap_o [3];
    logic       ovf_o  [3];

    int n_cmp = 0;
    int n_bad = 0;

    const int mod_c [3] = '{10, 10, 16};
    const int sat_c [3] = '{0, 1, 0};

    int mq [3];
    int mw [3];
    int mo [3];

    typedef struct packed {
        logic [2:0][3:0] q;
        logic [2:0]      w;
        logic [2:0]      o;
    } exp_t;

    exp_t sb [$];
    exp_t e;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0)) u_wrap10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
        .q(q_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0])
`ifdef PARAM_COUNTER_OVF_STICKY_EN
        , .ovf_sticky(ovf_o[0])
`endif
    );

    param_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1)) u_sat10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
        .q(q_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1])
`ifdef PARAM_COUNTER_OVF_STICKY_EN
        , .ovf_sticky(ovf_o[1])
`endif
    );

    param_updown_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0)) u_wrap16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
        .q(q_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2])
`ifdef PARAM_COUNTER_OVF_STICKY_EN
        , .ovf_sticky(ovf_o[2])
`endif
    );

`ifndef PARAM_COUNTER_OVF_STICKY_EN
    initial for (int i = 0; i < 3; i++) ovf_o[i] = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, check tc on the current count, then
    // advance the reference model and queue the post-edge expectation.
    task automatic step(input logic r, input logic ld, input int v,
                        input logic e_in, input logic u_in);
        exp_t x;
        @(negedge clk);
        #1;
        rst  = r;
        load = ld;
        lv   = 4'(v);
        en   = e_in;
        up   = u_in;
        #1;
        for (int i = 0; i < 3; i++) begin
            int mx;
            mx = mod_c[i] - 1;
            if (mq[i] >= 0)
                check_val($sformatf("tc%0d", i), 32'(tc_o[i]),
                          32'(u_in ? (mq[i] == mx) : (mq[i] == 0)));
        end
        for (int i = 0; i < 3; i++) begin
            int mx;
            mx = mod_c[i] - 1;
            if (r) begin
                mq[i] = 0; mw[i] = 0; mo[i] = 0;
            end else if (mq[i] < 0) begin
                mw[i] = 0;
            end else if (ld) begin
                mq[i] = (v > mx) ? mx : v;
                mw[i] = 0;
                mo[i] = 0;
            end else if (e_in) begin
                mw[i] = 0;
                if (u_in && mq[i] == mx) begin
                    mo[i] = 1;
                    if (sat_c[i] == 0) begin mq[i] = 0; mw[i] = 1; end
                end else if (!u_in && mq[i] == 0) begin
                    mo[i] = 1;
                    if (sat_c[i] == 0) begin mq[i] = mx; mw[i] = 1; end
                end else begin
                    mq[i] = u_in ? mq[i] + 1 : mq[i] - 1;
                end
            end else begin
                mw[i] = 0;
            end
            x.q[i] = 4'(mq[i]);
            x.w[i] = mw[i][0];
            x.o[i] = mo[i][0];
        end
        if (mq[0] >= 0) sb.push_back(x);
    endtask

    // Scoreboard consumer: one expectation per clock, checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                check_val($sformatf("q%0d", i), 32'(q_o[i]), 32'(e.q[i]));
                check_val($sformatf("wrap%0d", i), 32'(wrap_o[i]), 32'(e.w[i]));
`ifdef PARAM_COUNTER_OVF_STICKY_EN
                check_val($sformatf("ovf%0d", i), 32'(ovf_o[i]), 32'(e.o[i]));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin mq[i] = -1; mw[i] = 0; mo[i] = 0; end

        // Reset, then count up through the wrap.
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 1);

        // Load 2, count down through zero.
        step(0, 1, 2, 0, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);

        // From 7 upward into saturation / wrap, then clear sticky by load.
        step(0, 1, 7, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1);
        step(0, 1, 0, 1, 1);

        // Load clamp, load beating enable, reset beating load.
        step(0, 1, 13, 0, 0);
        step(0, 1, 4, 1, 1);
        step(1, 1, 7, 1, 1);

        // Count to 5, flip direction, then hold with en=0 while up toggles.
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        // Full-range modulus corners: up from 15, down from 0.
        step(0, 1, 15, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Saturate at zero going down.
        step(0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0);

        // Random mix.
        for (int k = 0; k < 60; k++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));

        @(negedge clk);
        @(negedge clk);
        check_val("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
